webp_mb_unpack: RTL and testbench
=================================

# webp_mb_unpack

Consumer end of the per-macroblock result FIFO filled by the WebP encode core. Pops the seven 1024-bit beats the encoder writes for each macroblock, reassembles them into one decoded macroblock record (AC/UV/DC levels, modes, nz, mbtype, skip, max_edge) and presents it to the downstream token/bitstream writer with a valid/ready handshake. It tracks macroblock position across the frame and pulses `done` after the last macroblock is accepted.

## Interface
- None (fixed format: 7 beats × 1024 bits per macroblock).

Ports:
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
- w1  in  10  last macroblock column index (mb_w−1).
- h1  in  10  last macroblock row index (mb_h−1).
- fifo_empty  in  1  result FIFO empty.
- fifo_rd  out  1  FIFO pop; read data valid the following cycle.
- fifo_dout  in  1024  FIFO read data.
- mb_valid  out  1  record valid; held until accepted.
- mb_ready  in  1  downstream accept.
- mb_x, mb_y  out  10 each  position of presented record.
- ac_levels  out  4096  beats 0–3, beat0 at [1023:0].
- uv_levels  out  2048  beats 4–5, beat4 at [1023:0].
- dc_levels  out  256  beat6[255:0].
- mode_i16  out  32  beat6[287:256].
- mode_i4  out  128  beat6[415:288].
- mode_uv  out  32  beat6[447:416].
- nz  out  32  beat6[479:448].
- mbtype  out  8  beat6[903:896].
- skipped  out  8  beat6[911:904].
- max_edge  out  32  beat6[959:928].
- fmt_err  out  1  sticky: reserved bits nonzero.
- done  out  1  one-cycle pulse after last record accepted.

## Operation
- States: IDLE, READ, OUT, DONE (one-hot).
- IDLE: x=y=0, issue/capture counters=0; `start` → READ; fmt_err cleared on `start`.
- READ: fifo_rd = !fifo_empty && issued<7; issued increments per pop. Registered rd_d1 captures fifo_dout into beat slot `captured` (0..6) on the next cycle; captured increments. Stalls on empty with no gaps or duplicate pops. When the 7th beat is captured → OUT.
- Beat 6 reserved fields [927:912], [895:480], [1023:960]: any nonzero bit sets fmt_err at capture; fields still decoded.
- OUT: mb_valid=1, all record outputs stable. mb_valid && mb_ready: counters cleared; if x>=w1 && y>=h1 → DONE, else x = (x>=w1)?0:x+1, y = (x>=w1)?y+1:y, → READ.
- DONE: done=1 for one cycle → IDLE.
- No prefetch: fifo_rd never asserted in OUT/DONE/IDLE; one record buffered.
- `start` outside IDLE ignored. Frame of 1×1 (w1=h1=0) is legal.

## Timing
- Reset: fifo_rd=0, mb_valid=0, done=0, fmt_err=0, mb_x=mb_y=0, all record outputs 0, state IDLE. Reset mid-frame aborts immediately; partially captured beats discarded.
- fifo_rd combinational from state/counter/fifo_empty; all other outputs registered.
- FIFO non-empty throughout: first fifo_rd in cycle after `start` (T); pops T..T+6; mb_valid high at T+8.
- mb_ready high at mb_valid rise: next fifo_rd one cycle after acceptance cycle; steady state 9 cycles/MB (+ empty stalls).
- mb_ready low: mb_valid and data held, no pops.
- done rises the cycle after the final acceptance; mb_valid low at that cycle.
- mb_x/mb_y reflect the presented record, update only on acceptance.

## Test plan
- Single MB (w1=h1=0), beats filled with pattern beatN = {128{8'hN}}, mbtype=1, skipped=0 → exactly 7 pops, mb_valid at T+8, ac_levels[1023:0]=all 8'h00, uv_levels[2047:1024]=all 8'h05, mbtype=1, done one cycle after acceptance.
- 3×2 frame (w1=2,h1=1), ready always 1 → 6 records in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 42 pops total; single done pulse.
- FIFO empty toggled every other cycle mid-record → no double pops, beat order preserved, record bit-exact vs. model.
- mb_ready held low 20 cycles → mb_valid/data stable, fifo_rd=0 throughout; accept on cycle 21.
- Beat 6 with bit 600 set → fmt_err=1 sticky through frame, record still delivered; cleared by next `start`.
- rst_n asserted after 3 beats captured → all outputs 0 immediately; new `start` reads fresh 7 beats correctly.

Source files
------------

// File: rtl/webp_mb_unpack.sv
// Pops seven 1024-bit result beats per macroblock, reassembles the decoded record and
// hands it downstream with valid/ready; walks the macroblock grid and pulses done at frame end.
module webp_mb_unpack (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [9:0]    w1,
   input  logic [9:0]    h1,
   input  logic          fifo_empty,
   output logic          fifo_rd,
   input  logic [1023:0] fifo_dout,
   output logic          mb_valid,
   input  logic          mb_ready,
   output logic [9:0]    mb_x,
   output logic [9:0]    mb_y,
   output logic [4095:0] ac_levels,
   output logic [2047:0] uv_levels,
   output logic [255:0]  dc_levels,
   output logic [31:0]   mode_i16,
   output logic [127:0]  mode_i4,
   output logic [31:0]   mode_uv,
   output logic [31:0]   nz,
   output logic [7:0]    mbtype,
   output logic [7:0]    skipped,
   output logic [31:0]   max_edge,
   output logic          fmt_err,
   output logic          done
);

   localparam logic [3:0] S_IDLE = 4'b0001;
   localparam logic [3:0] S_READ = 4'b0010;
   localparam logic [3:0] S_OUT  = 4'b0100;
   localparam logic [3:0] S_DONE = 4'b1000;

   logic [3:0]    state_q, state_d;
   logic [2:0]    issued_q, issued_d;
   logic [2:0]    captured_q, captured_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          fmt_err_q, fmt_err_d;
   logic          rd_d1_q;

   logic [4095:0] ac_q;
   logic [2047:0] uv_q;
   logic [255:0]  dc_q;
   logic [31:0]   mode_i16_q;
   logic [127:0]  mode_i4_q;
   logic [31:0]   mode_uv_q;
   logic [31:0]   nz_q;
   logic [7:0]    mbtype_q;
   logic [7:0]    skipped_q;
   logic [31:0]   max_edge_q;

   logic          accept;
   logic          last_beat;
   logic          beat6_bad;

   // Pops stop once all seven beats of this record are issued; no prefetch past the record.
   assign fifo_rd   = state_q[1] && !fifo_empty && (issued_q != 3'd7);
   assign accept    = state_q[2] && mb_ready;
   assign last_beat = rd_d1_q && (captured_q == 3'd6);
   assign beat6_bad = (|fifo_dout[1023:960]) || (|fifo_dout[927:912]) || (|fifo_dout[895:480]);

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      captured_d = captured_q;
      x_d        = x_q;
      y_d        = y_q;
      fmt_err_d  = fmt_err_q;
      case (state_q)
         S_IDLE: begin
            x_d        = '0;
            y_d        = '0;
            issued_d   = '0;
            captured_d = '0;
            if (start) begin
               state_d   = S_READ;
               fmt_err_d = 1'b0;
            end
         end
         S_READ: begin
            if (fifo_rd) issued_d = issued_q + 3'd1;
            if (rd_d1_q) captured_d = captured_q + 3'd1;
            if (last_beat) begin
               state_d = S_OUT;
               if (beat6_bad) fmt_err_d = 1'b1;
            end
         end
         S_OUT: begin
            if (accept) begin
               issued_d   = '0;
               captured_d = '0;
               if ((x_q >= w1) && (y_q >= h1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
                  x_d     = (x_q >= w1) ? 10'd0 : x_q + 10'd1;
                  y_d     = (x_q >= w1) ? y_q + 10'd1 : y_q;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         issued_q   <= '0;
         captured_q <= '0;
         x_q        <= '0;
         y_q        <= '0;
         fmt_err_q  <= 1'b0;
         rd_d1_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         captured_q <= captured_d;
         x_q        <= x_d;
         y_q        <= y_d;
         fmt_err_q  <= fmt_err_d;
         rd_d1_q    <= fifo_rd;
      end
   end

   // Read data lands one cycle after the pop; the capture counter picks the beat slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ac_q       <= '0;
         uv_q       <= '0;
         dc_q       <= '0;
         mode_i16_q <= '0;
         mode_i4_q  <= '0;
         mode_uv_q  <= '0;
         nz_q       <= '0;
         mbtype_q   <= '0;
         skipped_q  <= '0;
         max_edge_q <= '0;
      end else if (rd_d1_q) begin
         case (captured_q)
            3'd0, 3'd1, 3'd2, 3'd3: ac_q[{captured_q[1:0], 10'd0} +: 1024] <= fifo_dout;
            3'd4: uv_q[1023:0]    <= fifo_dout;
            3'd5: uv_q[2047:1024] <= fifo_dout;
            3'd6: begin
               dc_q       <= fifo_dout[255:0];
               mode_i16_q <= fifo_dout[287:256];
               mode_i4_q  <= fifo_dout[415:288];
               mode_uv_q  <= fifo_dout[447:416];
               nz_q       <= fifo_dout[479:448];
               mbtype_q   <= fifo_dout[903:896];
               skipped_q  <= fifo_dout[911:904];
               max_edge_q <= fifo_dout[959:928];
            end
            default: ;
         endcase
      end
   end

   assign mb_valid  = state_q[2];
   assign done      = state_q[3];
   assign fmt_err   = fmt_err_q;
   assign mb_x      = x_q;
   assign mb_y      = y_q;
   assign ac_levels = ac_q;
   assign uv_levels = uv_q;
   assign dc_levels = dc_q;
   assign mode_i16  = mode_i16_q;
   assign mode_i4   = mode_i4_q;
   assign mode_uv   = mode_uv_q;
   assign nz        = nz_q;
   assign mbtype    = mbtype_q;
   assign skipped   = skipped_q;
   assign max_edge  = max_edge_q;

endmodule

// File: tb/tb_webp_mb_unpack.sv
// Bench for webp_mb_unpack: FIFO model with registered read data, record reference built
// from beat layout rules, scenario tasks run in sequence.
module tb_webp_mb_unpack;

   localparam int RW = 6672;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [9:0]    w1, h1;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd;
   logic [1023:0] fifo_dout = '0;
   logic          mb_valid;
   logic          mb_ready;
   logic [9:0]    mb_x, mb_y;
   logic [4095:0] ac_levels;
   logic [2047:0] uv_levels;
   logic [255:0]  dc_levels;
   logic [31:0]   mode_i16;
   logic [127:0]  mode_i4;
   logic [31:0]   mode_uv;
   logic [31:0]   nz;
   logic [7:0]    mbtype;
   logic [7:0]    skipped;
   logic [31:0]   max_edge;
   logic          fmt_err;
   logic          done;

   webp_mb_unpack dut (
      .clk(clk), .rst_n(rst_n), .start(start), .w1(w1), .h1(h1),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
      .mb_valid(mb_valid), .mb_ready(mb_ready), .mb_x(mb_x), .mb_y(mb_y),
      .ac_levels(ac_levels), .uv_levels(uv_levels), .dc_levels(dc_levels),
      .mode_i16(mode_i16), .mode_i4(mode_i4), .mode_uv(mode_uv), .nz(nz),
      .mbtype(mbtype), .skipped(skipped), .max_edge(max_edge),
      .fmt_err(fmt_err), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   int underflow = 0;
   bit gate_en = 1'b0;
   bit gate = 1'b0;
   logic [1023:0] fifo_q[$];
   logic [1023:0] cur[7];
   logic [RW-1:0] got;

   assign got = {ac_levels, uv_levels, dc_levels, mode_i16, mode_i4, mode_uv, nz,
                 mbtype, skipped, max_edge};

   // Result FIFO model: pop on fifo_rd, data valid the next cycle.
   always @(posedge clk) begin
      if (fifo_rd) begin
         if (fifo_empty || fifo_q.size() == 0) underflow++;
         else begin
            fifo_dout <= fifo_q.pop_front();
            pop_cnt++;
         end
      end
      #1;
      if (gate_en) gate = !gate; else gate = 1'b0;
      fifo_empty = (fifo_q.size() == 0) || gate;
   end

   function automatic logic [1023:0] rand_beat();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic make_mb(input bit pattern, input bit bad);
      logic [7:0] nb;
      for (int n = 0; n < 7; n++) begin
         nb = 8'(n);
         cur[n] = pattern ? {128{nb}} : rand_beat();
      end
      cur[6][1023:960] = '0;
      cur[6][927:912]  = '0;
      cur[6][895:480]  = '0;
      if (pattern) begin
         cur[6][903:896] = 8'h01;
         cur[6][911:904] = 8'h00;
      end
      if (bad) cur[6][600] = 1'b1;
      for (int n = 0; n < 7; n++) fifo_q.push_back(cur[n]);
   endtask

   function automatic logic [RW-1:0] exp_rec();
      return {cur[3], cur[2], cur[1], cur[0], cur[5], cur[4],
              cur[6][255:0], cur[6][287:256], cur[6][415:288], cur[6][447:416],
              cur[6][479:448], cur[6][903:896], cur[6][911:904], cur[6][959:928]};
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int cyc = 0;
      while (!mb_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic accept();
      mb_ready = 1'b1;
      @(negedge clk);
      mb_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (fifo_rd !== 1'b0)  begin errors++; $display("FAIL reset_fifo_rd got %b exp 0", fifo_rd); end
      checks++; if (mb_valid !== 1'b0) begin errors++; $display("FAIL reset_mb_valid got %b exp 0", mb_valid); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (fmt_err !== 1'b0)  begin errors++; $display("FAIL reset_fmt_err got %b exp 0", fmt_err); end
      checks++; if ({mb_x, mb_y} !== 20'd0) begin errors++; $display("FAIL reset_pos got %0d,%0d exp 0,0", mb_x, mb_y); end
      checks++; if (got !== '0) begin errors++; $display("FAIL reset_record got_lo %h exp 0", got[127:0]); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int first_rd = -1, first_v = -1, base;
      logic [1023:0] k5;
      logic [RW-1:0] e;
      k5 = {128{8'h05}};
      w1 = 10'd0; h1 = 10'd0;
      make_mb(1'b1, 1'b0);
      e = exp_rec();
      repeat (2) @(negedge clk);
      base = pop_cnt;
      pulse_start();
      for (int c = 0; c < 12; c++) begin
         if (fifo_rd && first_rd < 0) first_rd = c;
         if (mb_valid && first_v < 0) first_v = c;
         @(negedge clk);
      end
      checks++; if (first_rd !== 0) begin errors++; $display("FAIL single_first_rd got %0d exp 0", first_rd); end
      checks++; if (first_v !== 8)  begin errors++; $display("FAIL single_valid_cycle got %0d exp 8", first_v); end
      checks++; if (pop_cnt - base !== 7) begin errors++; $display("FAIL single_pops got %0d exp 7", pop_cnt - base); end
      checks++; if (ac_levels[1023:0] !== '0) begin errors++; $display("FAIL single_ac0 got %h exp 0", ac_levels[127:0]); end
      checks++; if (uv_levels[2047:1024] !== k5) begin errors++; $display("FAIL single_uv5 got %h exp %h", uv_levels[1151:1024], k5[127:0]); end
      checks++; if (mbtype !== 8'h01) begin errors++; $display("FAIL single_mbtype got %h exp 01", mbtype); end
      checks++; if (got !== e) begin errors++; $display("FAIL single_record got_lo %h exp_lo %h", got[127:0], e[127:0]); end
      accept();
      checks++; if (done !== 1'b1 || mb_valid !== 1'b0) begin errors++; $display("FAIL single_done got done=%b valid=%b exp 1,0", done, mb_valid); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_frame();
      logic [RW-1:0] exp_q[$];
      int vcyc[6];
      int k = 0, dones = 0, prefetch = 0, badgap = 0, base;
      w1 = 10'd2; h1 = 10'd1;
      for (int i = 0; i < 6; i++) begin
         make_mb(1'b0, 1'b0);
         exp_q.push_back(exp_rec());
      end
      repeat (2) @(negedge clk);
      base = pop_cnt;
      mb_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 100; c++) begin
         if (mb_valid && k < 6) begin
            checks++;
            if (got !== exp_q[k] || mb_x !== 10'(k % 3) || mb_y !== 10'(k / 3)) begin
               errors++;
               $display("FAIL frame_rec%0d got pos %0d,%0d lo %h exp pos %0d,%0d lo %h",
                        k, mb_x, mb_y, got[127:0], k % 3, k / 3, exp_q[k][127:0]);
            end
            vcyc[k] = c;
            k++;
         end
         if (done) dones++;
         if (fifo_rd && mb_valid) prefetch++;
         @(negedge clk);
      end
      mb_ready = 1'b0;
      for (int i = 1; i < 6; i++) if (i < k && vcyc[i] - vcyc[i-1] != 9) badgap++;
      checks++; if (k !== 6) begin errors++; $display("FAIL frame_records got %0d exp 6", k); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL frame_done_pulses got %0d exp 1", dones); end
      checks++; if (pop_cnt - base !== 42) begin errors++; $display("FAIL frame_pops got %0d exp 42", pop_cnt - base); end
      checks++; if (prefetch !== 0) begin errors++; $display("FAIL frame_prefetch got %0d exp 0", prefetch); end
      checks++; if (badgap !== 0) begin errors++; $display("FAIL frame_cadence got %0d bad gaps exp 0", badgap); end
   endtask

   task automatic test_empty_toggle();
      int base;
      logic [RW-1:0] e;
      w1 = 10'd0; h1 = 10'd0;
      make_mb(1'b0, 1'b0);
      e = exp_rec();
      repeat (2) @(negedge clk);
      base = pop_cnt;
      gate_en = 1'b1;
      pulse_start();
      wait_valid();
      gate_en = 1'b0;
      checks++; if (mb_valid !== 1'b1) begin errors++; $display("FAIL toggle_valid got %b exp 1", mb_valid); end
      checks++; if (got !== e) begin errors++; $display("FAIL toggle_record got_lo %h exp_lo %h", got[127:0], e[127:0]); end
      checks++; if (pop_cnt - base !== 7) begin errors++; $display("FAIL toggle_pops got %0d exp 7", pop_cnt - base); end
      checks++; if (underflow !== 0) begin errors++; $display("FAIL toggle_empty_pops got %0d exp 0", underflow); end
      accept();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done got %b exp 1", done); end
   endtask

   task automatic test_backpressure();
      int bad = 0, base;
      logic [RW-1:0] e0, e1;
      w1 = 10'd1; h1 = 10'd0;
      make_mb(1'b0, 1'b0); e0 = exp_rec();
      make_mb(1'b0, 1'b0); e1 = exp_rec();
      repeat (2) @(negedge clk);
      base = pop_cnt;
      pulse_start();
      wait_valid();
      for (int c = 0; c < 20; c++) begin
         if (!mb_valid || got !== e0 || fifo_rd || mb_x !== 10'd0) bad++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
      checks++; if (pop_cnt - base !== 7) begin errors++; $display("FAIL bp_no_prefetch got %0d pops exp 7", pop_cnt - base); end
      accept();
      wait_valid();
      checks++; if (got !== e1 || mb_x !== 10'd1 || mb_y !== 10'd0) begin errors++; $display("FAIL bp_second got pos %0d,%0d lo %h exp pos 1,0 lo %h", mb_x, mb_y, got[127:0], e1[127:0]); end
      accept();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
   endtask

   task automatic test_fmt_err();
      logic [RW-1:0] e0, e1;
      w1 = 10'd1; h1 = 10'd0;
      make_mb(1'b0, 1'b1); e0 = exp_rec();
      make_mb(1'b0, 1'b0); e1 = exp_rec();
      repeat (2) @(negedge clk);
      pulse_start();
      wait_valid();
      checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_set got %b exp 1", fmt_err); end
      checks++; if (got !== e0) begin errors++; $display("FAIL fmt_record got_lo %h exp_lo %h", got[127:0], e0[127:0]); end
      accept();
      wait_valid();
      checks++; if (fmt_err !== 1'b1 || got !== e1) begin errors++; $display("FAIL fmt_sticky got err=%b lo %h exp err=1 lo %h", fmt_err, got[127:0], e1[127:0]); end
      accept();
      @(negedge clk);
      checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_idle got %b exp 1", fmt_err); end
      w1 = 10'd0; h1 = 10'd0;
      make_mb(1'b0, 1'b0); e0 = exp_rec();
      repeat (2) @(negedge clk);
      pulse_start();
      checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL fmt_clear got %b exp 0", fmt_err); end
      wait_valid();
      accept();
   endtask

   task automatic test_reset_mid();
      int base;
      logic [RW-1:0] e;
      w1 = 10'd0; h1 = 10'd0;
      make_mb(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (fifo_rd !== 1'b0 || mb_valid !== 1'b0 || done !== 1'b0 || fmt_err !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got rd=%b v=%b d=%b e=%b exp 0000", fifo_rd, mb_valid, done, fmt_err); end
      checks++; if (got !== '0 || {mb_x, mb_y} !== 20'd0) begin errors++; $display("FAIL midrst_record got_lo %h exp 0", got[127:0]); end
      fifo_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      make_mb(1'b0, 1'b0);
      e = exp_rec();
      repeat (2) @(negedge clk);
      base = pop_cnt;
      pulse_start();
      wait_valid();
      checks++; if (got !== e || mb_valid !== 1'b1) begin errors++; $display("FAIL midrst_fresh got v=%b lo %h exp v=1 lo %h", mb_valid, got[127:0], e[127:0]); end
      checks++; if (pop_cnt - base !== 7) begin errors++; $display("FAIL midrst_pops got %0d exp 7", pop_cnt - base); end
      accept();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got %b exp 1", done); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mb_ready = 1'b0; w1 = 10'd0; h1 = 10'd0;
      test_reset();
      test_single();
      test_frame();
      test_empty_toggle();
      test_backpressure();
      test_fmt_err();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
